// File: rtl/mem_arbiter_if.sv
// Cache-side request/completion signals and memory-side block bus of mem_arbiter.
// slave = arbiter view; master = the caches plus memory around it.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    logic                  CS;
    logic                  OE;
    logic                  WE;
    logic [ADDR_WIDTH-1:0] Addr;
    logic [DATA_WIDTH-1:0] Data_in;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  Ready_Mem;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata, err,
        output CS, OE, WE, Addr, Data_in,
        input  Data_out, Ready_Mem
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata, err,
        input  CS, OE, WE, Addr, Data_in,
        output Data_out, Ready_Mem
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port block-miss sequencer (port 0 I-cache, port 1 D-cache) onto a Ready_Mem block memory.
// Latency req->done >= 4 cycles (IDLE, ISSUE, BUSY for memory latency, DONE); ISSUE aborts after TIMEOUT.
// Requests are held until done; loser is delayed. `define ARB_ROUND_ROBIN_EN for round robin, else port 1 wins.
module mem_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int                    CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_OFS_MASK = ADDR_WIDTH'(15);

    logic [1:0]            r_state;
    logic                  r_id;
    logic                  r_we;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_any;
    logic                  w_grant;
    logic                  w_gnt1;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    assign w_any   = bus.req0 | bus.req1;
    assign w_grant = (r_state == S_IDLE) && w_any && bus.Ready_Mem;

`ifdef ARB_ROUND_ROBIN_EN
    // r_last1 = port 1 was granted last; its reset value lets port 0 win the first contention.
    logic r_last1;

    assign w_gnt1 = bus.req1 & (~bus.req0 | ~r_last1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last1 <= 1'b1;
        end else if (w_grant) begin
            r_last1 <= w_gnt1;
        end
    end
`else
    assign w_gnt1 = bus.req1;
`endif

    assign w_sel_we    = w_gnt1 ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_id    <= w_gnt1;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr & ~BLK_OFS_MASK;
                        r_wdata <= w_sel_we ? w_sel_wdata : '0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Memory accepting the command wins over a timeout in the same cycle.
                    if (!bus.Ready_Mem) begin
                        r_state <= S_BUSY;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_BUSY: begin
                    if (bus.Ready_Mem) begin
                        if (!r_we) begin
                            r_rdata <= bus.Data_out;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Controls are decoded from state so CS drops in BUSY and memory cannot re-trigger.
    assign bus.CS      = (r_state == S_ISSUE);
    assign bus.WE      = (r_state == S_ISSUE) &  r_we;
    assign bus.OE      = (r_state == S_ISSUE) & ~r_we;
    assign bus.Addr    = r_addr;
    assign bus.Data_in = r_wdata;

    assign bus.done0   = (r_state == S_DONE) & ~r_id;
    assign bus.done1   = (r_state == S_DONE) &  r_id;
    assign bus.err     = (r_state == S_DONE) &  r_err;
    assign bus.rdata   = r_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural Ready_Mem memory plus a done-ordered scoreboard.
module tb_mem_arbiter;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam logic [DW-1:0] BLK1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [DW-1:0] WBLK = 128'hAAAAAAAA_11111111_22222222_BBBBBBBB;
    localparam logic [DW-1:0] JUNK = {4{32'hDEADBEEF}};

    typedef struct packed {
        logic          port;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [DW-1:0] mem     [16];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_rdata;
    bit            mem_loaded = 1'b0;

    bit            m_busy;
    int            m_cnt;
    int            m_lat;
    bit            m_stuck;
    int            m_starts = 0;
    logic          m_we;
    logic          m_oe;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    int   cs_cycles = 0;
    int   we_cycles = 0;
    int   we_bad    = 0;
    int   done0_cnt = 0;
    int   done1_cnt = 0;
    logic last_port = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_cs"},      DW'(bus.CS),      '0);
        chk({p, "_oe"},      DW'(bus.OE),      '0);
        chk({p, "_we"},      DW'(bus.WE),      '0);
        chk({p, "_addr"},    DW'(bus.Addr),    '0);
        chk({p, "_datain"},  bus.Data_in,      '0);
        chk({p, "_rdata"},   bus.rdata,        '0);
        chk({p, "_done0"},   DW'(bus.done0),   '0);
        chk({p, "_done1"},   DW'(bus.done1),   '0);
        chk({p, "_err"},     DW'(bus.err),     '0);
    endtask

    // Memory: drops Ready_Mem on a CS it sees while idle, completes m_lat cycles later.
    always @(negedge clk) begin
        if (rst) begin
            if (!mem_loaded) begin
                for (int i = 0; i < 16; i++) mem[i] = '0;
                mem[1]     = BLK1;
                mem_loaded = 1'b1;
            end
            m_busy        = 1'b0;
            m_cnt         = 0;
            bus.Ready_Mem = 1'b1;
            bus.Data_out  = '0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                if (m_we) begin
                    mem[m_addr[7:4]] = m_wdata;
                    bus.Data_out     = JUNK;
                end else begin
                    bus.Data_out = mem[m_addr[7:4]];
                end
                bus.Ready_Mem = 1'b1;
                m_busy        = 1'b0;
            end else begin
                m_cnt--;
            end
        end else if (bus.CS && !m_stuck) begin
            m_busy        = 1'b1;
            bus.Ready_Mem = 1'b0;
            m_cnt         = m_lat;
            m_we          = bus.WE;
            m_oe          = bus.OE;
            m_addr        = bus.Addr;
            m_wdata       = bus.Data_in;
            m_starts++;
        end
    end

    // Monitor: activity counters and scoreboard pop on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.CS) cs_cycles++;
            if (bus.WE) we_cycles++;
            if (bus.WE && !bus.CS) we_bad++;
            if (bus.done0 || bus.done1) begin
                chk("single_done", DW'(bus.done0 & bus.done1), '0);
                chk("cs_low_at_done", DW'(bus.CS), '0);
                if (bus.done0) done0_cnt++;
                else done1_cnt++;
                last_port = bus.done1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", DW'(bus.done0 | bus.done1), '0);
                end else begin
                    e = sb.pop_front();
                    chk("done_port", DW'(bus.done1), DW'(e.port));
                    chk("done_err", DW'(bus.err), DW'(e.err));
                    chk("done_rdata", bus.rdata, e.rdata);
                end
            end
        end
    end

    task automatic xfer(input bit port, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit exp_err, input string tag);
        exp_t e;
        bit   got = 1'b0;
        if (!exp_err) begin
            if (we) ref_mem[a[7:4]] = wd;
            else exp_rdata = ref_mem[a[7:4]];
        end
        e.port  = port;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        sb.push_back(e);
        if (port) begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1;
        end else begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            // Once issued, the arbiter must ignore further address/data changes.
            if (bus.CS) begin
                if (port) begin bus.addr1 = $urandom; bus.wdata1 = {4{$urandom}}; end
                else begin bus.addr0 = $urandom; bus.wdata0 = {4{$urandom}}; end
            end
            got = port ? bus.done1 : bus.done0;
        end
        chk(tag, DW'(got), DW'(1));
        if (port) bus.req1 = 1'b0;
        else bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int   d0, w0, c0, s0, n;
        bit   got, first, fp, seen;
        exp_t e;

        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        m_lat = 2; m_stuck = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        ref_mem[1] = BLK1;
        exp_rdata  = '0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Unaligned read from port 0.
        d0 = done0_cnt;
        xfer(1'b0, 1'b0, 32'h0000_0013, '0, 1'b0, "t1_done");
        chk("t1_addr", DW'(m_addr), DW'(32'h10));
        chk("t1_oe", DW'(m_oe), DW'(1));
        chk("t1_we", DW'(m_we), '0);
        chk("t1_datain_zero", m_wdata, '0);
        chk("t1_done0_once", DW'(done0_cnt - d0), DW'(1));

        // Write from port 1, then read it back on port 0.
        w0 = we_cycles;
        xfer(1'b1, 1'b1, 32'h20, WBLK, 1'b0, "t2_done");
        chk("t2_we", DW'(m_we), DW'(1));
        chk("t2_oe", DW'(m_oe), '0);
        chk("t2_addr", DW'(m_addr), DW'(32'h20));
        chk("t2_datain", m_wdata, WBLK);
        chk("t2_we_cycles", DW'(we_cycles - w0), DW'(1));
        xfer(1'b0, 1'b0, 32'h20, '0, 1'b0, "t3_done");
        chk("t3_rdata_held", bus.rdata, WBLK);

        // Contention.
`ifdef ARB_ROUND_ROBIN_EN
        first = ~last_port;
`else
        first = 1'b1;
`endif
        e.err = 1'b0;
        e.port = first;  e.rdata = first ? WBLK : BLK1; sb.push_back(e);
        e.port = ~first; e.rdata = first ? BLK1 : WBLK; sb.push_back(e);
        exp_rdata = e.rdata;
        bus.we0 = 1'b0; bus.addr0 = 32'h10; bus.we1 = 1'b0; bus.addr1 = 32'h20;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        seen = 1'b0; fp = 1'b0;
        for (int i = 0; i < 400 && (bus.req0 || bus.req1); i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                if (!seen) fp = bus.done1;
                seen = 1'b1;
            end
            if (bus.done0) bus.req0 = 1'b0;
            if (bus.done1) bus.req1 = 1'b0;
        end
        chk("t4_both_served", DW'(bus.req0 | bus.req1), '0);
        chk("t4_first_winner", DW'(fp), DW'(first));
        @(negedge clk);

        // Memory never starts: timeout abort.
        m_stuck = 1'b1; c0 = cs_cycles; s0 = m_starts;
        xfer(1'b1, 1'b0, 32'h40, '0, 1'b1, "t5_done");
        chk("t5_issue_cycles", DW'(cs_cycles - c0), DW'(15));
        chk("t5_no_mem_start", DW'(m_starts - s0), '0);
        chk("t5_rdata_held", bus.rdata, exp_rdata);
        m_stuck = 1'b0;

        // Reset during BUSY.
        m_lat = 10; d0 = done0_cnt;
        bus.we0 = 1'b0; bus.addr0 = 32'h10; bus.req0 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            got = m_busy && !bus.CS;
        end
        chk("t6_reached_busy", DW'(got), DW'(1));
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_midreset");
        exp_rdata = '0;
        bus.req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_done", DW'(done0_cnt - d0), '0);
        m_lat = 2;
        xfer(1'b0, 1'b0, 32'h13, '0, 1'b0, "t6_after_reset");

        // Back-to-back reads with req0 held.
        d0 = done0_cnt;
        e.port = 1'b0; e.err = 1'b0; e.rdata = ref_mem[2];
        sb.push_back(e); sb.push_back(e);
        exp_rdata = ref_mem[2];
        bus.we0 = 1'b0; bus.addr0 = 32'h20; bus.req0 = 1'b1;
        n = 0;
        for (int i = 0; i < 400 && n < 2; i++) begin
            @(negedge clk);
            if (bus.done0) begin
                n++;
                if (n == 2) begin
                    bus.req0 = 1'b0;
                end else begin
                    @(negedge clk);
                    chk("t7_cs_gap", DW'(bus.CS), '0);
                end
            end
        end
        chk("t7_two_dones", DW'(n), DW'(2));
        @(negedge clk);
        chk("t7_done0_count", DW'(done0_cnt - d0), DW'(2));

        repeat (5) @(negedge clk);
        chk("sb_drained", DW'(sb.size()), '0);
        chk("we_only_in_issue", DW'(we_bad), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
